// File: rtl/seg7_fmt_if.sv
// Handshake and result bundle between the display register and seg7_fmt.
// master = requester side (CPU/register), slave = the formatter itself.
interface seg7_fmt_if #(
   parameter int IN_WIDTH = 32
) ();
   logic                start;
   logic                hex_mode;
   logic [IN_WIDTH-1:0] value;
   logic                busy;
   logic                done;
   logic [63:0]         numbers;

   modport master (
      output start, hex_mode, value,
      input  busy, done, numbers
   );

   modport slave (
      input  start, hex_mode, value,
      output busy, done, numbers
   );
endinterface

// File: rtl/seg7_fmt.sv
// Formats a value into eight 7-segment glyph bytes (hex, or decimal via double dabble).
// Optional macro SEG7_FMT_SIGNED_EN: decimal mode treats value as two's complement.
module seg7_fmt #(
   parameter int          IN_WIDTH    = 32,
   parameter logic [7:0]  OVF_PATTERN = 8'b00000010
) (
   input  logic      clk,
   input  logic      rst_n,
   seg7_fmt_if.slave bus
);
   localparam int BCD_CALC   = (IN_WIDTH * 30103) / 100000 + 1;
   localparam int BCD_DIGITS = (BCD_CALC < 8) ? 8 : BCD_CALC;
   localparam int BCD_BITS   = 4 * BCD_DIGITS;
   localparam int CNT_W      = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST   = CNT_W'(IN_WIDTH - 1);
   localparam logic [7:0]       SIGN_GLYPH = 8'h02;

   typedef enum logic [1:0] {IDLE, CONVERT, ENCODE} state_t;

   state_t              state_reg, state_next;
   logic [CNT_W-1:0]    cnt_reg, cnt_next;
   logic [BCD_BITS-1:0] bcd_reg, bcd_next;
   logic [IN_WIDTH-1:0] shift_reg, shift_next;
   logic                hex_reg, hex_next;
   logic                ovf_reg, ovf_next;
   logic                done_reg, done_next;
   logic [63:0]         numbers_reg, numbers_next;

   logic [IN_WIDTH-1:0] mag_in;
   logic                ovf_in;
   logic [BCD_BITS-1:0] adj;
   logic [BCD_BITS-1:0] step;
   logic                unused_adj_top;
   logic [7:1]          lead;
   logic [63:0]         hex_word;
   logic [63:0]         dec_word;

   function automatic logic [7:0] glyph(input logic [3:0] d);
      case (d)
         4'h0: glyph = 8'hFC;  4'h1: glyph = 8'h60;
         4'h2: glyph = 8'hDA;  4'h3: glyph = 8'hF2;
         4'h4: glyph = 8'h66;  4'h5: glyph = 8'hB6;
         4'h6: glyph = 8'hBE;  4'h7: glyph = 8'hE0;
         4'h8: glyph = 8'hFE;  4'h9: glyph = 8'hE6;
         4'hA: glyph = 8'hEE;  4'hB: glyph = 8'h3E;
         4'hC: glyph = 8'h1A;  4'hD: glyph = 8'h7A;
         4'hE: glyph = 8'h9E;  default: glyph = 8'h8E;
      endcase
   endfunction

`ifdef SEG7_FMT_SIGNED_EN
   logic neg_in, neg_reg, neg_next;
   assign neg_in = bus.value[IN_WIDTH-1];
   assign mag_in = neg_in ? (IN_WIDTH'(0) - bus.value) : bus.value;
   // A negative number needs one digit for the sign, so its limit is a decade lower.
   assign ovf_in = neg_in ? (64'(mag_in) > 64'd9_999_999) : (64'(mag_in) > 64'd99_999_999);
`else
   assign mag_in = bus.value;
   assign ovf_in = 64'(mag_in) > 64'd99_999_999;
`endif

   genvar gi;
   generate
      for (gi = 0; gi < BCD_DIGITS; gi++) begin : g_dabble
         assign adj[4*gi +: 4] = (bcd_reg[4*gi +: 4] >= 4'd5) ? bcd_reg[4*gi +: 4] + 4'd3
                                                              : bcd_reg[4*gi +: 4];
      end
      for (gi = 0; gi < 8; gi++) begin : g_digit
         assign hex_word[8*gi +: 8] = glyph(shift_reg[4*gi +: 4]);
         if (gi == 0) begin : g_units
            assign dec_word[7:0] = ovf_reg ? OVF_PATTERN : glyph(bcd_reg[3:0]);
         end else begin : g_upper
            assign lead[gi] = |bcd_reg[31:4*gi];
`ifdef SEG7_FMT_SIGNED_EN
            // Sign sits exactly one place left of the most significant shown digit.
            assign dec_word[8*gi +: 8] = ovf_reg  ? OVF_PATTERN :
                                         lead[gi] ? glyph(bcd_reg[4*gi +: 4]) :
                                         (neg_reg && bcd_reg[4*(gi-1) +: 4] != 4'd0) ? SIGN_GLYPH :
                                         8'h00;
`else
            assign dec_word[8*gi +: 8] = ovf_reg  ? OVF_PATTERN :
                                         lead[gi] ? glyph(bcd_reg[4*gi +: 4]) : 8'h00;
`endif
         end
      end
   endgenerate

   // The top BCD digit can never reach 8 for the widths used, so its carry-out is dropped.
   assign step           = {adj[BCD_BITS-2:0], shift_reg[IN_WIDTH-1]};
   assign unused_adj_top = adj[BCD_BITS-1];

   always_comb begin
      state_next   = state_reg;
      cnt_next     = cnt_reg;
      bcd_next     = bcd_reg;
      shift_next   = shift_reg;
      hex_next     = hex_reg;
      ovf_next     = ovf_reg;
      done_next    = 1'b0;
      numbers_next = numbers_reg;
`ifdef SEG7_FMT_SIGNED_EN
      neg_next     = neg_reg;
`endif
      case (state_reg)
         IDLE: begin
            if (bus.start) begin
               hex_next   = bus.hex_mode;
               shift_next = bus.hex_mode ? bus.value : mag_in;
               ovf_next   = ovf_in;
               cnt_next   = '0;
               bcd_next   = '0;
`ifdef SEG7_FMT_SIGNED_EN
               neg_next   = neg_in && !bus.hex_mode;
`endif
               state_next = bus.hex_mode ? ENCODE : CONVERT;
            end
         end
         CONVERT: begin
            bcd_next   = step;
            shift_next = {shift_reg[IN_WIDTH-2:0], 1'b0};
            cnt_next   = cnt_reg + CNT_W'(1);
            if (cnt_reg == CNT_LAST) begin
               state_next = ENCODE;
            end
         end
         ENCODE: begin
            numbers_next = hex_reg ? hex_word : dec_word;
            done_next    = 1'b1;
            state_next   = IDLE;
         end
         default: state_next = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_reg   <= IDLE;
         cnt_reg     <= '0;
         bcd_reg     <= '0;
         shift_reg   <= '0;
         hex_reg     <= 1'b0;
         ovf_reg     <= 1'b0;
         done_reg    <= 1'b0;
         numbers_reg <= '0;
`ifdef SEG7_FMT_SIGNED_EN
         neg_reg     <= 1'b0;
`endif
      end else begin
         state_reg   <= state_next;
         cnt_reg     <= cnt_next;
         bcd_reg     <= bcd_next;
         shift_reg   <= shift_next;
         hex_reg     <= hex_next;
         ovf_reg     <= ovf_next;
         done_reg    <= done_next;
         numbers_reg <= numbers_next;
`ifdef SEG7_FMT_SIGNED_EN
         neg_reg     <= neg_next;
`endif
      end
   end

   assign bus.busy    = (state_reg != IDLE);
   assign bus.done    = done_reg;
   assign bus.numbers = numbers_reg;
endmodule

// File: tb/tb_seg7_fmt.sv
// Directed self-checking bench for seg7_fmt: latency, glyph words, blanking, overflow,
// start-while-busy, asynchronous abort and back-to-back starts.
module tb_seg7_fmt;
   logic clk;
   logic rst_n;
   int   pass_cnt;
   int   total_cnt;

   seg7_fmt_if #(.IN_WIDTH(32)) bus ();

   seg7_fmt #(.IN_WIDTH(32), .OVF_PATTERN(8'b00000010)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Starts one conversion from an aligned point (#1 after an edge) and waits for done.
   task automatic run_conv(input logic h, input logic [31:0] v, output int lat,
                           output logic [63:0] res, output logic busy_ok);
      bus.hex_mode = h;
      bus.value    = v;
      bus.start    = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      busy_ok   = bus.busy;
      lat       = -1;
      for (int c = 1; c <= 100; c++) begin
         @(posedge clk); #1;
         if (bus.done) begin
            if (bus.busy) busy_ok = 1'b0;
            lat = c;
            break;
         end else if (!bus.busy) begin
            busy_ok = 1'b0;
         end
      end
      res = bus.numbers;
      $display("txn hex=%0d value=%h numbers=%h latency=%0d", h, v, res, lat);
   endtask

   task automatic check_conv(input string name, input logic h, input logic [31:0] v,
                             input logic [63:0] exp_num);
      int          lat;
      logic [63:0] res;
      logic        busy_ok;
      int          exp_lat;
      exp_lat = h ? 1 : 33;
      run_conv(h, v, lat, res, busy_ok);
      total_cnt++;
      if (res !== exp_num) $display("FAIL %s numbers: got %h expected %h", name, res, exp_num);
      else pass_cnt++;
      total_cnt++;
      if (lat != exp_lat) $display("FAIL %s latency: got %0d expected %0d", name, lat, exp_lat);
      else pass_cnt++;
      total_cnt++;
      if (busy_ok !== 1'b1) $display("FAIL %s busy: got %b expected 1", name, busy_ok);
      else pass_cnt++;
   endtask

   task automatic test_reset();
      total_cnt++;
      if (bus.numbers !== 64'h0) $display("FAIL reset numbers: got %h expected 0", bus.numbers);
      else pass_cnt++;
      total_cnt++;
      if (bus.busy !== 1'b0) $display("FAIL reset busy: got %b expected 0", bus.busy);
      else pass_cnt++;
      total_cnt++;
      if (bus.done !== 1'b0) $display("FAIL reset done: got %b expected 0", bus.done);
      else pass_cnt++;
   endtask

   task automatic test_hex();
      check_conv("hex_1234ABCD", 1'b1, 32'h1234ABCD, 64'h60DAF266EE3E1A7A);
      check_conv("hex_zero",     1'b1, 32'h00000000, 64'hFCFCFCFCFCFCFCFC);
      check_conv("hex_9E8F0070", 1'b1, 32'h9E8F0070, 64'hE69EFE8EFCFCE0FC);
   endtask

   task automatic test_decimal();
      check_conv("dec_12345",    1'b0, 32'd12345,       64'h00000060DAF266B6);
      check_conv("dec_zero",     1'b0, 32'd0,           64'h00000000000000FC);
      check_conv("dec_10000",    1'b0, 32'd10000,       64'h00000060FCFCFCFC);
      check_conv("dec_max",      1'b0, 32'd99_999_999,  64'hE6E6E6E6E6E6E6E6);
      check_conv("dec_ovf",      1'b0, 32'd100_000_000, 64'h0202020202020202);
      // numbers must hold between conversions
      repeat (4) @(posedge clk);
      #1;
      total_cnt++;
      if (bus.numbers !== 64'h0202020202020202)
         $display("FAIL hold numbers: got %h expected %h", bus.numbers, 64'h0202020202020202);
      else pass_cnt++;
   endtask

   task automatic test_ignore_start();
      int done_cnt;
      int done_at;
      bus.hex_mode = 1'b0;
      bus.value    = 32'd555;
      bus.start    = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      done_cnt  = 0;
      done_at   = -1;
      for (int c = 1; c <= 60; c++) begin
         @(posedge clk); #1;
         bus.start = 1'b0;
         if (bus.done) begin
            done_cnt++;
            if (done_at < 0) done_at = c;
         end
         if (c == 5 || c == 20) begin
            bus.value = 32'd999;
            bus.start = 1'b1;
         end
      end
      bus.start = 1'b0;
      $display("txn ignore_start value=555 numbers=%h dones=%0d first_done=%0d", bus.numbers, done_cnt, done_at);
      total_cnt++;
      if (done_cnt != 1) $display("FAIL ignore_start done count: got %0d expected 1", done_cnt);
      else pass_cnt++;
      total_cnt++;
      if (done_at != 33) $display("FAIL ignore_start latency: got %0d expected 33", done_at);
      else pass_cnt++;
      total_cnt++;
      if (bus.numbers !== 64'h0000000000B6B6B6)
         $display("FAIL ignore_start numbers: got %h expected %h", bus.numbers, 64'h0000000000B6B6B6);
      else pass_cnt++;
   endtask

   task automatic test_abort();
      bus.hex_mode = 1'b0;
      bus.value    = 32'd123456;
      bus.start    = 1'b1;
      @(posedge clk); #1;
      bus.start = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      $display("txn abort numbers=%h busy=%b done=%b", bus.numbers, bus.busy, bus.done);
      total_cnt++;
      if (bus.numbers !== 64'h0) $display("FAIL abort numbers: got %h expected 0", bus.numbers);
      else pass_cnt++;
      total_cnt++;
      if (bus.busy !== 1'b0) $display("FAIL abort busy: got %b expected 0", bus.busy);
      else pass_cnt++;
      #2;
      rst_n = 1'b1;
      @(posedge clk); #1;
      check_conv("after_abort_42", 1'b0, 32'd42, 64'h00000000000066DA);
   endtask

   task automatic test_back_to_back();
      int done_cnt;
      int bad_busy;
      bus.hex_mode = 1'b1;
      bus.value    = 32'h00000001;
      bus.start    = 1'b1;
      done_cnt = 0;
      bad_busy = 0;
      for (int c = 0; c < 20; c++) begin
         @(posedge clk); #1;
         if (bus.done) done_cnt++;
         if (bus.busy === bus.done) bad_busy++;
      end
      bus.start = 1'b0;
      @(posedge clk); #1;
      $display("txn back_to_back hex dones=%0d busy_violations=%0d numbers=%h", done_cnt, bad_busy, bus.numbers);
      total_cnt++;
      if (done_cnt != 10) $display("FAIL b2b done count: got %0d expected 10", done_cnt);
      else pass_cnt++;
      total_cnt++;
      if (bad_busy != 0) $display("FAIL b2b busy pattern: got %0d violations expected 0", bad_busy);
      else pass_cnt++;
      total_cnt++;
      if (bus.numbers !== 64'hFCFCFCFCFCFCFC60)
         $display("FAIL b2b numbers: got %h expected %h", bus.numbers, 64'hFCFCFCFCFCFCFC60);
      else pass_cnt++;
      // let any conversion accepted at the final held-start edge drain
      repeat (3) @(posedge clk);
      #1;
   endtask

   task automatic test_signed();
`ifdef SEG7_FMT_SIGNED_EN
      check_conv("signed_neg42",    1'b0, 32'hFFFFFFD6, 64'h00000000000266DA);
      check_conv("signed_neg10M",   1'b0, 32'hFF676980, 64'h0202020202020202);
      check_conv("signed_neg9999999", 1'b0, 32'hFF676981, 64'h02E6E6E6E6E6E6E6);
      check_conv("signed_hex_neg",  1'b1, 32'hFFFFFFD6, 64'h8E8E8E8E8E8E7ABE);
`else
      check_conv("unsigned_big",    1'b0, 32'hFFFFFFD6, 64'h0202020202020202);
      check_conv("unsigned_2p31",   1'b0, 32'h80000000, 64'h0202020202020202);
`endif
   endtask

   initial begin
      pass_cnt     = 0;
      total_cnt    = 0;
      rst_n        = 1'b0;
      bus.start    = 1'b0;
      bus.hex_mode = 1'b0;
      bus.value    = 32'h0;
      repeat (3) @(posedge clk);
      #1;
      test_reset();
      rst_n = 1'b1;
      @(posedge clk); #1;
      test_hex();
      test_decimal();
      test_ignore_start();
      test_abort();
      test_back_to_back();
      test_signed();
      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end
endmodule
